// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token code words and the decoder alignment FSM states.
package tmds_pkg;

   localparam logic [9:0] TokCtl0 = 10'h354;
   localparam logic [9:0] TokCtl1 = 10'h0AB;
   localparam logic [9:0] TokCtl2 = 10'h154;
   localparam logic [9:0] TokCtl3 = 10'h2AB;

   typedef enum logic [1:0] {
      StSearch,
      StVerify,
      StLocked
   } tmds_state_e;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS 10b word decode: control-token match plus 8b video data recovery.
module tmds_word_decode
   import tmds_pkg::*;
(
   input  logic [9:0] word,
   output logic [7:0] vd,
   output logic [1:0] cd,
   output logic       is_token
);

   logic [7:0] q;

   always_comb begin
      q        = word[9] ? ~word[7:0] : word[7:0];
      vd       = 8'h00;
      cd       = 2'b00;
      is_token = 1'b1;
      unique case (word)
         TokCtl0: cd = 2'b00;
         TokCtl1: cd = 2'b01;
         TokCtl2: cd = 2'b10;
         TokCtl3: cd = 2'b11;
         default: begin
            is_token = 1'b0;
            vd[0]    = q[0];
            // word[8] selects XOR vs XNOR transition coding
            for (int i = 1; i < 8; i++) begin
               vd[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
            end
         end
      endcase
   end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: serial-to-word alignment on control tokens, lock tracking with a
// data-word watchdog, and registered per-word outputs.
module tmds_decoder
   import tmds_pkg::*;
#(
   parameter int unsigned LOCK_COUNT = 8,
   parameter int unsigned WDOG_WORDS = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sdata,
   output logic [7:0] vd,
   output logic [1:0] cd,
   output logic       vde,
   output logic       word_valid,
   output logic       locked,
   output logic       sync_err
);

   localparam int unsigned LockW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned WdogW = $clog2(WDOG_WORDS + 1);

   tmds_state_e      state_q, state_d;
   logic [9:0]       win_q;
   logic [3:0]       phase_q, phase_d;
   logic [LockW-1:0] lock_q, lock_d, lock_next;
   logic [WdogW-1:0] wdog_q, wdog_d, wdog_next;
   logic [7:0]       dec_vd;
   logic [1:0]       dec_cd;
   logic             dec_tok;
   logic             boundary, lock_full, wdog_full;
   logic             emit, drop;

   tmds_word_decode u_word_decode (
      .word     (win_q),
      .vd       (dec_vd),
      .cd       (dec_cd),
      .is_token (dec_tok)
   );

   // Window is aligned to a full word in the cycle the phase counter is about to wrap
   assign boundary  = (phase_q == 4'd9);
   assign lock_next = lock_q + LockW'(1);
   assign wdog_next = wdog_q + WdogW'(1);
   assign lock_full = (lock_next == LockW'(LOCK_COUNT));
   assign wdog_full = (wdog_next == WdogW'(WDOG_WORDS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StSearch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StSearch: if (dec_tok) state_d = StVerify;
         StVerify: begin
            if (boundary) begin
               if (!dec_tok)       state_d = StSearch;
               else if (lock_full) state_d = StLocked;
            end
         end
         StLocked: if (boundary && !dec_tok && wdog_full) state_d = StSearch;
         default:  state_d = StSearch;
      endcase
   end

   always_comb begin
      locked = (state_q == StLocked);
      drop   = locked && boundary && !dec_tok && wdog_full;
      emit   = locked && boundary && !drop;
   end

   always_comb begin
      phase_d = boundary ? 4'd0 : phase_q + 4'd1;
      lock_d  = lock_q;
      wdog_d  = wdog_q;
      if (state_q == StSearch && dec_tok) begin
         phase_d = 4'd0;
         lock_d  = LockW'(1);
      end else if (state_q == StVerify && boundary && dec_tok) begin
         lock_d = lock_next;
      end
      if (state_q != StLocked) begin
         wdog_d = '0;
      end else if (boundary) begin
         wdog_d = dec_tok ? '0 : wdog_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q      <= '0;
         phase_q    <= '0;
         lock_q     <= '0;
         wdog_q     <= '0;
         vd         <= '0;
         cd         <= '0;
         vde        <= 1'b0;
         word_valid <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         win_q      <= {sdata, win_q[9:1]};
         phase_q    <= phase_d;
         lock_q     <= lock_d;
         wdog_q     <= wdog_d;
         word_valid <= emit;
         sync_err   <= drop;
         if (emit) begin
            vd  <= dec_vd;
            cd  <= dec_cd;
            vde <= ~dec_tok;
         end
      end
   end

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: per-scenario tasks with a queue scoreboard of
// expected {vde, cd, vd} words consumed on each word_valid pulse.
module tb_tmds_decoder;

   localparam int unsigned LockCnt = 8;
   localparam int unsigned WdogCnt = 1024;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sdata;
   logic [7:0] vd;
   logic [1:0] cd;
   logic       vde;
   logic       word_valid;
   logic       locked;
   logic       sync_err;

   logic [10:0] exp_q[$];
   logic [10:0] mon_exp;
   int          pass_cnt  = 0;
   int          total_cnt = 0;

   always #5 clk = ~clk;

   tmds_decoder #(
      .LOCK_COUNT (LockCnt),
      .WDOG_WORDS (WdogCnt)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sdata      (sdata),
      .vd         (vd),
      .cd         (cd),
      .vde        (vde),
      .word_valid (word_valid),
      .locked     (locked),
      .sync_err   (sync_err)
   );

   // Scoreboard consumer: every word_valid must match the oldest expected word
   always @(negedge clk) begin
      if (rst_n === 1'b1 && word_valid === 1'b1) begin
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_valid got %h required no pulse", {vde, cd, vd});
         end else begin
            mon_exp = exp_q.pop_front();
            if ({vde, cd, vd} !== mon_exp)
               $display("FAIL word got %h required %h", {vde, cd, vd}, mon_exp);
            else
               pass_cnt++;
         end
      end
   end

   task automatic send_bit(input logic b);
      sdata = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [9:0] w);
      for (int i = 0; i < 10; i++) send_bit(w[i]);
   endtask

   // Sends n 0x354 tokens from an aligned start; checks the exact lock edge
   task automatic lock_stream(input int n);
      logic [9:0] tok;
      tok = 10'h354;
      for (int t = 1; t <= n; t++) begin
         for (int i = 0; i < 10; i++) begin
            send_bit(tok[i]);
            if (t == LockCnt + 1 && i == 0) begin
               total_cnt++;
               if (locked !== 1'b1) $display("FAIL lock_rise got %b required 1", locked);
               else pass_cnt++;
            end
         end
         if (t == LockCnt) begin
            total_cnt++;
            if (locked !== 1'b0) $display("FAIL lock_early got %b required 0", locked);
            else pass_cnt++;
         end
         if (t > LockCnt) exp_q.push_back({1'b0, 2'b00, 8'h00});
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      sdata = 1'b0;
      #1;
      total_cnt++;
      if ({vd, cd, vde, word_valid, locked, sync_err} !== 14'h0)
         $display("FAIL reset_async got %h required 0", {vd, cd, vde, word_valid, locked, sync_err});
      else pass_cnt++;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if ({vd, cd, vde, word_valid, locked, sync_err} !== 14'h0)
         $display("FAIL reset_hold got %h required 0", {vd, cd, vde, word_valid, locked, sync_err});
      else pass_cnt++;
      rst_n = 1'b1;
   endtask

   task automatic test_lock;
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      lock_stream(20);
   endtask

   task automatic test_data;
      logic [9:0]  words[4] = '{10'h100, 10'h200, 10'h1F0, 10'h0F0};
      logic [7:0]  vals[4]  = '{8'h00, 8'hFF, 8'h10, 8'hEE};
      for (int k = 0; k < 4; k++) begin
         send_word(words[k]);
         exp_q.push_back({1'b1, 2'b00, vals[k]});
      end
   endtask

   task automatic test_tokens;
      logic [9:0] toks[3] = '{10'h0AB, 10'h154, 10'h2AB};
      logic [1:0] cds[3]  = '{2'b01, 2'b10, 2'b11};
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 10; i++) begin
            send_bit(toks[k][i]);
            if (k == 0 && i == 5) begin
               total_cnt++;
               if ({word_valid, vde, cd, vd} !== {1'b0, 1'b1, 2'b00, 8'hEE})
                  $display("FAIL hold got %h required %h", {word_valid, vde, cd, vd},
                           {1'b0, 1'b1, 2'b00, 8'hEE});
               else pass_cnt++;
            end
         end
         exp_q.push_back({1'b0, cds[k], 8'h00});
      end
   endtask

   task automatic test_reset_mid;
      logic [9:0] tok;
      tok = 10'h354;
      for (int i = 0; i < 4; i++) send_bit(tok[i]);
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({vd, cd, vde, word_valid, locked, sync_err} !== 14'h0)
         $display("FAIL reset_mid got %h required 0", {vd, cd, vde, word_valid, locked, sync_err});
      else pass_cnt++;
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL reset_pending got %0d required 0", exp_q.size());
      else pass_cnt++;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      lock_stream(10);
   endtask

   task automatic test_watchdog;
      for (int w = 1; w <= int'(WdogCnt); w++) begin
         send_word(10'h100);
         if (w < int'(WdogCnt)) exp_q.push_back({1'b1, 2'b00, 8'h00});
      end
      total_cnt++;
      if ({locked, sync_err} !== 2'b10)
         $display("FAIL wdog_pre got %b required 10", {locked, sync_err});
      else pass_cnt++;
      send_bit(1'b0);
      total_cnt++;
      if ({locked, sync_err, word_valid} !== 3'b010)
         $display("FAIL wdog_drop got %b required 010", {locked, sync_err, word_valid});
      else pass_cnt++;
      send_bit(1'b0);
      total_cnt++;
      if (sync_err !== 1'b0) $display("FAIL sync_width got %b required 0", sync_err);
      else pass_cnt++;
      repeat (3) send_bit(1'b0);
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL wdog_count got %0d left required 0", exp_q.size());
      else pass_cnt++;
   endtask

   task automatic test_abort;
      for (int t = 0; t < 5; t++) send_word(10'h354);
      send_word(10'h100);
      send_bit(1'b0);
      total_cnt++;
      if ({locked, word_valid} !== 2'b00)
         $display("FAIL abort got %b required 00", {locked, word_valid});
      else pass_cnt++;
      // Finish the 0x100-aligned slot with zeros so the next tokens start aligned
      for (int i = 1; i < 10; i++) send_bit(1'b0);
      lock_stream(9);
      send_bit(1'b0);
      send_bit(1'b0);
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL abort_count got %0d left required 0", exp_q.size());
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_lock();
      test_data();
      test_tokens();
      test_reset_mid();
      test_watchdog();
      test_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 8, meaning the number of consecutive same-phase control tokens needed to declare lock.
REQ-002 SHALL have parameter WDOG_WORDS, default 1024, meaning the number of aligned words without a control token after which lock drops.
REQ-003 SHALL have port clk  input  1  bit clock; one serial bit per cycle; sole clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sdata  input  1  serial TMDS channel bit, word LSB first.
REQ-006 SHALL have port vd  output  8  decoded video data.
REQ-007 SHALL have port cd  output  2  decoded control data {cd[1],cd[0]}.
REQ-008 SHALL have port vde  output  1  1 = word was video data, 0 = word was a control token.
REQ-009 SHALL have port word_valid  output  1  one-cycle pulse qualifying vd/cd/vde.
REQ-010 SHALL have port locked  output  1  word alignment established.
REQ-011 SHALL have port sync_err  output  1  one-cycle pulse when lock is lost by watchdog.

Function
REQ-012 SHALL shift sdata into a 10-bit window each cycle as {sdata, win[9:1]}, so win[0] holds the earliest bit.
REQ-013 SHALL recognise control tokens 0x354->cd=00, 0x0AB->cd=01, 0x154->cd=10, 0x2AB->cd=11; all other words are data.
REQ-014 SHALL decode a data word as: q = win[9] ? ~win[7:0] : win[7:0]; vd[0]=q[0]; for i=1..7, vd[i] = win[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
REQ-015 SHALL implement FSM SEARCH, VERIFY, LOCKED with a mod-10 phase counter, a lock counter of width clog2(LOCK_COUNT+1), and a watchdog counter of width clog2(WDOG_WORDS+1).
REQ-016 In SEARCH, any cycle whose window equals a control token SHALL zero the phase counter, set the lock count to 1, and enter VERIFY.
REQ-017 A word boundary SHALL be the cycle where the phase counter wraps from 9 to 0.
REQ-018 In VERIFY, a token at a boundary SHALL increment the lock count; on reaching LOCK_COUNT the FSM SHALL enter LOCKED and set locked=1 on that clock edge.
REQ-019 In VERIFY, a data word at a boundary SHALL return the FSM to SEARCH without asserting sync_err.
REQ-020 In LOCKED, each boundary SHALL register the decoded word and pulse word_valid on the following cycle (latency 1 clk after the 10th bit).
REQ-021 For a token word, outputs SHALL be vde=0, vd=0x00, cd=token value.
REQ-022 For a data word, outputs SHALL be vde=1, cd=00, vd=decoded value.
REQ-023 word_valid SHALL NOT assert in SEARCH or VERIFY; vd/cd/vde SHALL hold their last values between pulses.
REQ-024 In LOCKED, the watchdog SHALL clear on each boundary token and increment on each boundary data word.
REQ-025 On the boundary where the watchdog reaches WDOG_WORDS, the FSM SHALL enter SEARCH, clear locked, and pulse sync_err for one cycle; no word_valid pulse SHALL be issued for that word.
REQ-026 A token matched at a non-boundary phase while LOCKED SHALL be ignored.

Reset
REQ-027 While rst_n=0, all outputs SHALL be 0, the window, counters and watchdog SHALL be 0, and the FSM SHALL be in SEARCH, asynchronously.
REQ-028 Reset asserted mid-word or while LOCKED SHALL discard partial words; after release, lock SHALL be re-acquired from SEARCH.

Structure
REQ-029 Package tmds_pkg SHALL hold the four control-token constants and the FSM state enum, shared with the encoder side.
REQ-030 Combinational word decoding SHALL live in sub-module tmds_word_decode (10-bit in; vd, cd, is_token out).

Verification
REQ-031 Reset: drive rst_n=0 mid-stream while locked -> locked=0, word_valid=0, and outputs 0 immediately, without waiting for a clock.
REQ-032 Lock: send 3 garbage bits, then 20x 0x354 -> locked rises at the 8th aligned token boundary; word_valid then pulses every 10 clk with cd=00 and vde=0.
REQ-033 Data: after lock, send 0x100 then 0x200 -> vd=0x00 then 0xFF, vde=1, cd=00.
REQ-034 Tokens: after lock, send 0x0AB, 0x154, 0x2AB -> cd=01, 10, 11, vde=0.
REQ-035 Abort: send 5x 0x354 then 0x100 -> locked stays 0, no word_valid, FSM returns to SEARCH.
REQ-036 Watchdog: after lock, send 1024 consecutive 0x100 words -> 1023 word_valid pulses; on the 1024th boundary, locked falls and sync_err pulses for one cycle.
